multdiv_ctrl: RTL and testbench
===============================

# multdiv_ctrl

Sequencing controller for the shared multi-cycle multiply/divide unit in the execute stage. It detects R-type MUL (ALU op 6) and DIV (ALU op 7) in the D/X latch and launches the operation with a one-cycle start pulse. It stalls the pipeline until the unit reports ready or a watchdog expires, then presents a single-cycle writeback. Overflow and divide-by-zero are redirected to the status register $r30.

## Interface
- MAX_CYCLES, 40, watchdog limit in BUSY cycles (≥ 2); counter width clog2(MAX_CYCLES+1)
- MUL_STATUS, 4, value written to $r30 on multiply exception or timeout
- DIV_STATUS, 5, value written to $r30 on divide exception or timeout

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- DXIR  in  32  instruction in D/X latch; opcode [31:27], rd [26:22], ALU op [6:2]
- dx_a, dx_b  in  32 each  execute-stage operands (post-bypass)
- flush  in  1  squash of D/X (taken branch/jump)
- md_resultRDY  in  1  unit result valid
- md_result  in  32  unit result
- md_exception  in  1  overflow / divide-by-zero, valid with md_resultRDY
- md_mult, md_div  out  1 each  one-cycle start pulses to the unit
- md_a, md_b  out  32 each  latched operands, stable for the whole operation
- stall  out  1  freeze F/D and D/X, insert bubble into X/M
- busy  out  1  state ≠ IDLE
- wb_valid  out  1  one-cycle register write request
- wb_rd  out  5  destination register
- wb_data  out  32  write data

## Operation
- is_md = DXIR[31:27]==0 && (DXIR[6:2]==6 || DXIR[6:2]==7).
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE
  - If is_md && !flush: latch dx_a/dx_b into md_a/md_b, rd, and op type (mult = ALU op 6). Go to BUSY.
  - If flush, no launch.
- BUSY
  - First cycle: md_mult or md_div = 1 per op type. Counter cleared to 0; increments each BUSY cycle.
  - md_resultRDY is ignored in the start-pulse cycle.
  - md_resultRDY && !flush: capture result and exception, go to DONE.
  - Counter == MAX_CYCLES-1 without ready: go to DONE with exception forced to 1.
  - flush without ready: go to DRAIN. flush with ready in the same cycle: go to IDLE, discard result.
- DONE (exactly one cycle)
  - wb_valid = 1.
  - No exception: wb_rd = latched rd, wb_data = result. wb_valid is suppressed if rd == 0.
  - Exception: wb_rd = 30, wb_data = MUL_STATUS or DIV_STATUS (zero-extended).
  - Next state: IDLE.
- DRAIN
  - Wait for md_resultRDY or watchdog expiry, then go to IDLE. No writeback.
- stall = (IDLE && is_md && !flush) || BUSY || (DRAIN && is_md && !flush). stall = 0 in DONE so the completed instruction leaves D/X at the end of DONE.
- Back-to-back: a second MUL/DIV arriving in D/X after DONE launches normally from IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0. All registered outputs are 0: md_mult, md_div, md_a, md_b, wb_valid, wb_rd, wb_data. busy = 0. stall is forced 0 while reset_n is low.
- Start pulse appears 1 cycle after detection.
- Ready at BUSY cycle k (k ≥ 1): wb_valid rises on the next cycle.
  - Total stall cycles = k + 2: detection cycle + k+1 BUSY cycles.
- md_a/md_b change only on the IDLE→BUSY transition.
- Watchdog: at most MAX_CYCLES BUSY cycles before DONE.
- Reset mid-operation aborts immediately. No writeback; the unit's pending ready is ignored after reset.

## Test plan
- MUL: DXIR op 6, rd=3, dx_a=7, dx_b=6; ready with 42 at BUSY cycle 16 -> md_mult one cycle; stall for 18 cycles; wb_valid=1, wb_rd=3, wb_data=42 for one cycle.
- DIV by zero: DXIR op 7, rd=4, dx_b=0; ready with md_exception=1 -> wb_rd=30, wb_data=5.
- Timeout: MUL launched, md_resultRDY never asserted, MAX_CYCLES=40 -> DONE after 40 BUSY cycles with wb_rd=30, wb_data=4; then IDLE.
- Flush in BUSY cycle 5, ready at cycle 20 -> DRAIN; no wb_valid; stall=0 during DRAIN; IDLE after ready.
- rd=0 MUL, no exception -> no wb_valid. Back-to-back MUL then DIV -> two separate start pulses, two writebacks in order.
- reset_n low at BUSY cycle 3 -> all outputs 0 at once; a later md_resultRDY produces no writeback.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencing controller for the shared multi-cycle MUL/DIV unit.
// Detects R-type MUL/DIV in D/X, launches the unit with a one-cycle start
// pulse, stalls the front of the pipe until the result (or watchdog) arrives,
// then issues a single-cycle writeback. Exceptions and timeouts are written to
// the status register $r30 instead of rd.
module multdiv_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int MUL_STATUS = 4,
  parameter int DIV_STATUS = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] DXIR,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic        flush,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        md_mult,
  output logic        md_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int            CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(MAX_CYCLES - 1);
  localparam logic [4:0]    STATUS_REG = 5'd30;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    rd_q;
  logic          mul_q;

  logic [4:0]  alu_op;
  logic        is_md, launch, first, rdy, expired, exc;
  logic [31:0] status;
  logic        unused_dxir;

  assign alu_op  = DXIR[6:2];
  assign is_md   = (DXIR[31:27] == 5'd0) && ((alu_op == 5'd6) || (alu_op == 5'd7));
  assign launch  = is_md && !flush;
  // The start pulse marks the first BUSY cycle; a ready seen there is stale.
  assign first   = md_mult | md_div;
  assign rdy     = md_resultRDY && !first;
  assign expired = (cnt >= CNT_LAST);
  // A timeout is reported exactly like a unit exception.
  assign exc     = rdy ? md_exception : 1'b1;
  assign status  = mul_q ? 32'(MUL_STATUS) : 32'(DIV_STATUS);
  assign unused_dxir = ^{DXIR[21:7], DXIR[1:0]};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a flush in BUSY wins over completion and watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = BUSY;
      BUSY: begin
        if (flush)                state_nxt = rdy ? IDLE : DRAIN;
        else if (rdy || expired)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      DRAIN:   if (md_resultRDY || expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pipeline control outputs; stall stays low while reset is asserted.
  always_comb begin
    busy  = (state != IDLE);
    stall = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE:    stall = launch;
        BUSY:    stall = 1'b1;
        DRAIN:   stall = launch;
        default: stall = 1'b0;
      endcase
    end
  end

  // Operand latch, start pulses, watchdog counter and registered writeback.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_mult  <= 1'b0;
      md_div   <= 1'b0;
      md_a     <= '0;
      md_b     <= '0;
      rd_q     <= '0;
      mul_q    <= 1'b0;
      cnt      <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      md_mult  <= 1'b0;
      md_div   <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      if (state == IDLE && launch) begin
        md_a    <= dx_a;
        md_b    <= dx_b;
        rd_q    <= DXIR[26:22];
        mul_q   <= (alu_op == 5'd6);
        md_mult <= (alu_op == 5'd6);
        md_div  <= (alu_op == 5'd7);
        cnt     <= '0;
      end else if (state == BUSY || state == DRAIN) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
      if (state == BUSY && state_nxt == DONE) begin
        wb_valid <= exc || (rd_q != 5'd0);
        wb_rd    <= exc ? STATUS_REG : rd_q;
        wb_data  <= exc ? status : md_result;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: randomized self-checking bench for multdiv_ctrl. Expected
// behaviour per cycle is derived from the operation's timeline (detection
// cycle, ready cycle, flush cycle) rather than from controller state.
module tb_multdiv_ctrl;

  localparam int MAXC = 40;
  localparam int MULS = 4;
  localparam int DIVS = 5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] DXIR, dx_a, dx_b, md_result;
  logic        flush, md_resultRDY, md_exception;
  logic        md_mult, md_div, stall, busy, wb_valid;
  logic [31:0] md_a, md_b, wb_data;
  logic [4:0]  wb_rd;

  int errors = 0;
  int checks = 0;

  multdiv_ctrl #(.MAX_CYCLES(MAXC), .MUL_STATUS(MULS), .DIV_STATUS(DIVS)) dut (
    .clock(clock), .reset_n(reset_n), .DXIR(DXIR), .dx_a(dx_a), .dx_b(dx_b),
    .flush(flush), .md_resultRDY(md_resultRDY), .md_result(md_result),
    .md_exception(md_exception), .md_mult(md_mult), .md_div(md_div),
    .md_a(md_a), .md_b(md_b), .stall(stall), .busy(busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  // R-type MUL/DIV word with random filler in the don't-care fields.
  function automatic logic [31:0] mk_md(input bit mul, input logic [4:0] rd);
    logic [31:0] w;
    w = $urandom;
    w[31:27] = 5'd0;
    w[26:22] = rd;
    w[6:2]   = mul ? 5'd6 : 5'd7;
    return w;
  endfunction

  function automatic logic [31:0] rand_nonmd();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == 5'd0 && (w[6:2] == 5'd6 || w[6:2] == 5'd7)) w[31:27] = 5'd1;
    return w;
  endfunction

  // One full operation from detection (c=0) through DONE. Ready arrives in
  // BUSY cycle k (absolute cycle k+1); a timeout op never sees ready.
  task automatic run_op(input bit mul, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int k, input bit tmo,
                        input logic [31:0] res, input bit exc, input string nm);
    int last;
    bit e, ev;
    logic [4:0]  er;
    logic [31:0] ed;
    last = tmo ? MAXC + 1 : k + 2;
    e    = tmo ? 1'b1 : exc;
    ev   = e || (rd != 5'd0);
    er   = e ? 5'd30 : rd;
    ed   = e ? (mul ? 32'(MULS) : 32'(DIVS)) : res;
    for (int c = 0; c <= last; c++) begin
      DXIR = mk_md(mul, rd);
      flush = 1'b0;
      dx_a = (c == 0) ? a : $urandom;
      dx_b = (c == 0) ? b : $urandom;
      md_resultRDY = 1'b0;
      md_result = $urandom;
      md_exception = 1'($urandom_range(1, 0));
      if (c == 1) md_resultRDY = 1'($urandom_range(1, 0));
      if (!tmo && c == k + 1) begin
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
      end
      @(negedge clock);
      checks++;
      if (stall !== 1'(c < last)) begin
        errors++; $display("FAIL %s_stall c=%0d got=%b exp=%b", nm, c, stall, c < last);
      end
      checks++;
      if (busy !== 1'(c >= 1)) begin
        errors++; $display("FAIL %s_busy c=%0d got=%b exp=%b", nm, c, busy, c >= 1);
      end
      checks++;
      if (md_mult !== 1'(c == 1 && mul) || md_div !== 1'(c == 1 && !mul)) begin
        errors++;
        $display("FAIL %s_start c=%0d got=%b%b exp=%b%b", nm, c, md_mult, md_div,
                 c == 1 && mul, c == 1 && !mul);
      end
      checks++;
      if (wb_valid !== 1'(c == last && ev)) begin
        errors++; $display("FAIL %s_wbv c=%0d got=%b exp=%b", nm, c, wb_valid, c == last && ev);
      end
      if (c >= 1) begin
        checks++;
        if (md_a !== a || md_b !== b) begin
          errors++; $display("FAIL %s_opnd c=%0d got=%h/%h exp=%h/%h", nm, c, md_a, md_b, a, b);
        end
      end
      if (c == last && ev) begin
        checks++;
        if (wb_rd !== er || wb_data !== ed) begin
          errors++; $display("FAIL %s_wb got=%0d/%h exp=%0d/%h", nm, wb_rd, wb_data, er, ed);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; DXIR = mk_md(1'b1, 5'd3); flush = 1'b0;
    md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'hdeadbeef;
    dx_a = 32'h11; dx_b = 32'h22;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got stall=%b busy=%b exp=0/0", stall, busy);
    end
    checks++;
    if ({md_mult, md_div, wb_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got=%b exp=000", {md_mult, md_div, wb_valid});
    end
    checks++;
    if (md_a !== 32'd0 || md_b !== 32'd0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      errors++; $display("FAIL reset_regs got=%h/%h/%0d/%h exp=0", md_a, md_b, wb_rd, wb_data);
    end
    @(posedge clock); #1;
    reset_n = 1'b1; DXIR = rand_nonmd(); md_resultRDY = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_release got busy=%b stall=%b exp=0/0", busy, stall);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_idle(input string nm);
    DXIR = rand_nonmd(); flush = 1'b0; md_resultRDY = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL %s_idle got busy=%b stall=%b wbv=%b exp=000", nm, busy, stall, wb_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_mul();
    run_op(1'b1, 5'd3, 32'd7, 32'd6, 16, 1'b0, 32'd42, 1'b0, "mul");
    test_idle("mul");
  endtask

  task automatic test_div0();
    run_op(1'b0, 5'd4, $urandom, 32'd0, 5, 1'b0, $urandom, 1'b1, "div0");
    test_idle("div0");
  endtask

  task automatic test_timeout();
    run_op(1'b1, 5'd9, $urandom, $urandom, 0, 1'b1, 32'd0, 1'b0, "tmo_mul");
    test_idle("tmo_mul");
    run_op(1'b0, 5'd2, $urandom, $urandom, 0, 1'b1, 32'd0, 1'b0, "tmo_div");
    test_idle("tmo_div");
  endtask

  task automatic test_rd0();
    run_op(1'b1, 5'd0, 32'd3, 32'd5, 4, 1'b0, 32'd15, 1'b0, "rd0");
    test_idle("rd0");
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 5'd5, 32'd9, 32'd9, 3, 1'b0, 32'd81, 1'b0, "b2b_mul");
    run_op(1'b0, 5'd6, 32'd81, 32'd9, 2, 1'b0, 32'd9, 1'b0, "b2b_div");
    test_idle("b2b");
  endtask

  // Flush in BUSY cycle f, ready in BUSY-numbered cycle r (while draining).
  // With md_next a new MUL/DIV sits in D/X during the drain and must launch.
  task automatic test_flush_drain(input bit md_next, input int f, input int r);
    logic [31:0] nxt;
    bit es;
    nxt = mk_md(1'b0, 5'd8);
    for (int c = 0; c <= r + 2; c++) begin
      DXIR = (c <= f + 1) ? mk_md(1'b1, 5'd7) : (md_next ? nxt : 32'd0);
      flush = (c == f + 1);
      md_resultRDY = (c == r + 1); md_exception = 1'b0; md_result = $urandom;
      dx_a = $urandom; dx_b = $urandom;
      @(negedge clock);
      es = (c <= f + 1) || md_next;
      checks++;
      if (stall !== es) begin
        errors++; $display("FAIL drain_stall c=%0d got=%b exp=%b", c, stall, es);
      end
      checks++;
      if (busy !== 1'(c >= 1 && c <= r + 1)) begin
        errors++; $display("FAIL drain_busy c=%0d got=%b exp=%b", c, busy, c >= 1 && c <= r + 1);
      end
      checks++;
      if (wb_valid !== 1'b0 || md_mult !== 1'(c == 1) || md_div !== 1'b0) begin
        errors++; $display("FAIL drain_out c=%0d got wbv=%b mult=%b div=%b exp=0/%b/0",
                           c, wb_valid, md_mult, md_div, c == 1);
      end
      @(posedge clock); #1;
    end
    if (md_next) begin
      DXIR = nxt; flush = 1'b0; md_resultRDY = 1'b1; md_exception = 1'b1;
      @(negedge clock);
      checks++;
      if (md_div !== 1'b1 || md_mult !== 1'b0 || busy !== 1'b1 || stall !== 1'b1) begin
        errors++; $display("FAIL drain_relaunch got div=%b mult=%b busy=%b stall=%b exp=1011",
                           md_div, md_mult, busy, stall);
      end
      @(posedge clock); #1;
      md_resultRDY = 1'b1; md_exception = 1'b0; md_result = 32'hcafe0008;
      @(negedge clock);
      checks++;
      if (stall !== 1'b1 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL drain_relaunch_rdy got stall=%b wbv=%b exp=1/0", stall, wb_valid);
      end
      @(posedge clock); #1;
      md_resultRDY = 1'b0;
      @(negedge clock);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 32'hcafe0008 || stall !== 1'b0) begin
        errors++; $display("FAIL drain_relaunch_wb got=%b/%0d/%h stall=%b exp=1/8/cafe0008 0",
                           wb_valid, wb_rd, wb_data, stall);
      end
      @(posedge clock); #1;
    end
    test_idle("drain");
  endtask

  task automatic test_flush_ready();
    for (int c = 0; c <= 6; c++) begin
      DXIR = (c <= 4) ? mk_md(1'b0, 5'd9) : 32'd0;
      flush = (c == 4);
      md_resultRDY = (c == 4); md_exception = 1'b0; md_result = 32'h77;
      @(negedge clock);
      checks++;
      if (busy !== 1'(c >= 1 && c <= 4) || stall !== 1'(c <= 4) || wb_valid !== 1'b0) begin
        errors++; $display("FAIL flush_rdy c=%0d got busy=%b stall=%b wbv=%b exp=%b/%b/0",
                           c, busy, stall, wb_valid, c >= 1 && c <= 4, c <= 4);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid();
    DXIR = mk_md(1'b1, 5'd11); dx_a = 32'h1234; dx_b = 32'h5678;
    flush = 1'b0; md_resultRDY = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    checks++;
    if (busy !== 1'b1 || md_a !== 32'h1234) begin
      errors++; $display("FAIL rstmid_pre got busy=%b md_a=%h exp=1/1234", busy, md_a);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({md_mult, md_div, wb_valid, busy, stall} !== 5'b0 || md_a !== 32'd0 || md_b !== 32'd0 ||
        wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      errors++; $display("FAIL rstmid_async got ctl=%b md_a=%h md_b=%h wb=%0d/%h exp=0",
                         {md_mult, md_div, wb_valid, busy, stall}, md_a, md_b, wb_rd, wb_data);
    end
    @(posedge clock); #1;
    reset_n = 1'b1; DXIR = 32'd0; md_resultRDY = 1'b1; md_exception = 1'b0;
    md_result = 32'h99;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || md_mult !== 1'b0) begin
        errors++; $display("FAIL rstmid_after c=%0d got wbv=%b busy=%b mult=%b exp=000",
                           c, wb_valid, busy, md_mult);
      end
      @(posedge clock); #1;
      md_resultRDY = 1'b0;
    end
  endtask

  task automatic test_random();
    bit mul, exc;
    logic [4:0] rd;
    int gap;
    for (int i = 0; i < 16; i++) begin
      mul = 1'($urandom_range(1, 0));
      exc = ($urandom_range(3, 0) == 0);
      rd  = (i % 5 == 0) ? 5'd0 : 5'($urandom);
      run_op(mul, rd, $urandom, $urandom, $urandom_range(10, 1), 1'b0, $urandom, exc, "rand");
      gap = $urandom_range(2, 0);
      for (int g = 0; g < gap; g++) begin
        DXIR = rand_nonmd(); flush = 1'($urandom_range(1, 0)); md_resultRDY = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
          errors++; $display("FAIL rand_gap i=%0d got busy=%b stall=%b wbv=%b exp=000",
                             i, busy, stall, wb_valid);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; DXIR = 32'd0; dx_a = 32'd0; dx_b = 32'd0; flush = 1'b0;
    md_resultRDY = 1'b0; md_result = 32'd0; md_exception = 1'b0;
    test_reset();
    test_mul();
    test_div0();
    test_timeout();
    test_rd0();
    test_back_to_back();
    test_flush_drain(1'b0, 5, 20);
    test_flush_drain(1'b1, 2, 6);
    test_flush_ready();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
